// File: rtl/reg_pipe_hs_if.sv
// reg_pipe_hs_if: stream bundle for the reg_pipe_hs elastic pipeline.
//
// Signals (named from the pipeline's point of view):
//   d, d_vld, d_rdy  upstream handshake into the pipe
//   q, q_vld, q_rdy  downstream handshake out of the pipe
//   sclr             synchronous clear, active-high
//   occ              number of valid stages
//
// Modports:
//   master  the environment: drives d/d_vld/q_rdy/sclr, observes the rest
//   slave   the pipeline itself
interface reg_pipe_hs_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OCC_W = 2
);
    logic             sclr;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic             d_rdy;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             q_rdy;
    logic [OCC_W-1:0] occ;

    modport master (
        output sclr, d, d_vld, q_rdy,
        input  d_rdy, q, q_vld, occ
    );

    modport slave (
        input  sclr, d, d_vld, q_rdy,
        output d_rdy, q, q_vld, occ
    );
endinterface

// File: rtl/reg_pipe_hs.sv
// reg_pipe_hs: WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits and
// valid/ready backpressure. A stage loads whenever it is empty or its contents move on,
// so bubbles collapse toward the output and the pipe absorbs up to DEPTH words.
//
// Ports:
//   sclk   system clock, rising edge
//   rst_n  asynchronous active-low reset (clears valid bits and occupancy)
//   bus    reg_pipe_hs_if.slave: d/d_vld/d_rdy in, q/q_vld/q_rdy out, sclr, occ
//
// Optional feature: define REG_PIPE_RESET_DATA_EN to put the data registers on the
// async reset and sclr (loading RST_VAL). Without it the data registers carry no reset,
// which keeps them SRL/retiming friendly; q is then unspecified until q_vld first rises.
module reg_pipe_hs #(
    parameter int unsigned     WIDTH   = 8,
    parameter int unsigned     DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned     OCC_W   = 2
) (
    input  logic          sclk,
    input  logic          rst_n,
    reg_pipe_hs_if.slave  bus
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] adv;
    logic             any_empty;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_xfer;
    logic             out_xfer;

    // adv[i] = ~vld[i] | adv[i+1], unrolled as "some stage at or after i is empty, or
    // the output is draining" so no signal feeds back on itself.
    always_comb begin
        any_empty = 1'b0;
        adv       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            any_empty = any_empty | ~vld_q[i];
            adv[i]    = any_empty | bus.q_rdy;
        end
    end

    assign bus.d_rdy = adv[0] & ~bus.sclr & rst_n;
    assign bus.q     = data_q[DEPTH-1];
    assign bus.q_vld = vld_q[DEPTH-1];
    assign bus.occ   = occ_q;

    assign in_xfer  = bus.d_vld & bus.d_rdy;
    assign out_xfer = vld_q[DEPTH-1] & bus.q_rdy;

    // Both transfers in one cycle leave occupancy unchanged.
    always_comb begin
        occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (bus.sclr) begin
            vld_q <= '0;
        end else begin
            if (adv[0]) vld_q[0] <= bus.d_vld;
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (bus.sclr) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef REG_PIPE_RESET_DATA_EN
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
        end else if (bus.sclr) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
        end else begin
            if (adv[0]) data_q[0] <= bus.d;
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) data_q[i] <= data_q[i-1];
            end
        end
    end
`else
    // No reset or clear on data: a stage shifting under sclr only loads don't-care
    // values because its valid bit is cleared at the same edge.
    always_ff @(posedge sclk) begin
        if (adv[0]) data_q[0] <= bus.d;
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) data_q[i] <= data_q[i-1];
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe_hs.sv
// tb_reg_pipe_hs: directed stimulus with a scoreboard queue for reg_pipe_hs
// (WIDTH=8, DEPTH=3, RST_VAL=8'hA5). Accepted words are queued; a negedge monitor pops
// and compares on every output transfer.
module tb_reg_pipe_hs;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;

    always #5 sclk = ~sclk;

    reg_pipe_hs_if #(.WIDTH(8), .OCC_W(2)) bus ();

    reg_pipe_hs #(
        .WIDTH   (8),
        .DEPTH   (3),
        .RST_VAL (8'hA5),
        .OCC_W   (2)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_out  = 0;
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output transfer must match the oldest accepted word.
    always @(negedge sclk) begin
        if (rst_n && bus.q_vld === 1'b1 && bus.q_rdy === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got q=%0h, expected no output (t=%0t)",
                         bus.q, $time);
            end else begin
                check("out_data", {24'h0, bus.q}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Called at posedge+1; drives one cycle, returns at the next posedge+1.
    task automatic cycle(input logic dv, input logic [7:0] dval, input logic qr,
                         input logic clr, output logic acc, output logic rdy);
        bus.d     = dval;
        bus.d_vld = dv;
        bus.q_rdy = qr;
        bus.sclr  = clr;
        @(negedge sclk);
        #1;
        rdy = bus.d_rdy;
        acc = dv & rdy;
        if (acc) exp_q.push_back(dval);
        if (clr) exp_q.delete();
        @(posedge sclk);
        #1;
    endtask

    logic acc, rdy;
    int unsigned n_base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.d = '0; bus.d_vld = 1'b0; bus.q_rdy = 1'b0; bus.sclr = 1'b0;

        // Reset values, before any clock edge.
        #3;
        check("rst_q_vld", {31'h0, bus.q_vld}, 32'h0);
        check("rst_occ",   {30'h0, bus.occ},   32'h0);
        check("rst_d_rdy", {31'h0, bus.d_rdy}, 32'h0);
`ifdef REG_PIPE_RESET_DATA_EN
        check("rst_q", {24'h0, bus.q}, 32'hA5);
`endif
        @(posedge sclk); #1;
        rst_n = 1'b1;

        // Latency: q_vld rises in the third cycle after the first word is presented.
        cycle(1'b1, 8'h11, 1'b1, 1'b0, acc, rdy);
        check("lat_acc0", {31'h0, acc}, 32'h1);
        check("lat_qvld0", {31'h0, bus.q_vld}, 32'h0);
        check("lat_occ1", {30'h0, bus.occ}, 32'h1);
        cycle(1'b1, 8'h22, 1'b1, 1'b0, acc, rdy);
        check("lat_qvld1", {31'h0, bus.q_vld}, 32'h0);
        check("lat_occ2", {30'h0, bus.occ}, 32'h2);
        cycle(1'b1, 8'h33, 1'b1, 1'b0, acc, rdy);
        check("lat_qvld2", {31'h0, bus.q_vld}, 32'h1);
        check("lat_q", {24'h0, bus.q}, 32'h11);
        check("lat_occ3", {30'h0, bus.occ}, 32'h3);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("lat_drain_occ", {30'h0, bus.occ}, 32'h0);
        check("lat_nout", n_out, 32'd3);

        // Backpressure: only three of five words fit.
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 8'(k), 1'b0, 1'b0, acc, rdy);
            check("bp_acc", {31'h0, acc}, (k <= 3) ? 32'h1 : 32'h0);
        end
        check("bp_occ", {30'h0, bus.occ}, 32'h3);
        check("bp_qvld", {31'h0, bus.q_vld}, 32'h1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("bp_rdy_back", {31'h0, rdy}, 32'h1);
        for (int k = 0; k < 2; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("bp_drain_occ", {30'h0, bus.occ}, 32'h0);
        check("bp_nout", n_out, 32'd6);

        // Bubble collapse: C0 and C1 separated by two idle cycles end up adjacent.
        cycle(1'b1, 8'hC0, 1'b0, 1'b0, acc, rdy);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, rdy);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, rdy);
        cycle(1'b1, 8'hC1, 1'b0, 1'b0, acc, rdy);
        check("bub_acc", {31'h0, acc}, 32'h1);
        check("bub_occ", {30'h0, bus.occ}, 32'h2);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, rdy);
        check("bub_q", {24'h0, bus.q}, 32'hC0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("bub_b2b_qvld", {31'h0, bus.q_vld}, 32'h1);
        check("bub_b2b_q", {24'h0, bus.q}, 32'hC1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("bub_occ0", {30'h0, bus.occ}, 32'h0);

        // sclr with the output stalled: everything discarded, EE never accepted.
        for (int k = 1; k <= 3; k++) cycle(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, acc, rdy);
        check("clr_full", {30'h0, bus.occ}, 32'h3);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, acc, rdy);
        check("clr_rdy", {31'h0, rdy}, 32'h0);
        check("clr_qvld", {31'h0, bus.q_vld}, 32'h0);
        check("clr_occ", {30'h0, bus.occ}, 32'h0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);

        // sclr coinciding with an output transfer: that word still counts as delivered.
        n_base = n_out;
        for (int k = 1; k <= 3; k++) cycle(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0, acc, rdy);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1, acc, rdy);
        check("clr2_nout", n_out - n_base, 32'd1);
        check("clr2_occ", {30'h0, bus.occ}, 32'h0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);

        // Full-pipe concurrency: one in, one out per cycle, occ pinned at 3.
        n_base = n_out;
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'hF0 + 8'(k), 1'b0, 1'b0, acc, rdy);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 8'h30 + 8'(k), 1'b1, 1'b0, acc, rdy);
            check("full_acc", {31'h0, acc}, 32'h1);
            check("full_occ", {30'h0, bus.occ}, 32'h3);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("full_nout", n_out - n_base, 32'd13);
        check("full_occ0", {30'h0, bus.occ}, 32'h0);

        // Async reset mid-stream, then restart: stale words must not reappear.
        cycle(1'b1, 8'h61, 1'b0, 1'b0, acc, rdy);
        cycle(1'b1, 8'h62, 1'b0, 1'b0, acc, rdy);
        bus.d = 8'h63; bus.d_vld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q_vld", {31'h0, bus.q_vld}, 32'h0);
        check("arst_occ",   {30'h0, bus.occ},   32'h0);
        check("arst_d_rdy", {31'h0, bus.d_rdy}, 32'h0);
`ifdef REG_PIPE_RESET_DATA_EN
        check("arst_q", {24'h0, bus.q}, 32'hA5);
`endif
        exp_q.delete();
        @(posedge sclk); #1;
        rst_n = 1'b1;
        n_base = n_out;
        cycle(1'b1, 8'h77, 1'b1, 1'b0, acc, rdy);
        check("post_rst_acc", {31'h0, acc}, 32'h1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, rdy);
        check("post_rst_nout", n_out - n_base, 32'd1);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
